uart_tx: RTL and testbench

Asynchronous serial transmitter that converts parallel bytes into UART frames on a single line. It pairs with the on-chip UART receiver and shares its frame configuration: data width, parity, stop bits and clocks-per-bit. Bytes arrive from the microcontroller bus side through a valid/ready handshake. `tx_out` drives the board pin or, in loopback benches, the receiver's `rx_in`.

---
 rtl/uart_tx_if.sv | 8 +
 rtl/uart_tx.sv | 148 ++++++++++++++
 tb/tb_uart_tx.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_if.sv
// uart_tx_if: valid/ready byte handshake between the bus side and uart_tx.
interface uart_tx_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   modport master (output tx_data, output tx_valid, input tx_ready);
   modport slave (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx.sv
// uart_tx: UART frame serializer with per-frame shadowed configuration.
// Define UART_TX_BREAK_EN to add the send_break input and the BREAK state.
module uart_tx #(
   parameter int SAMPLE_WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    enable,
   input  logic [3:0]              data_width,
   input  logic [1:0]              parity,
   input  logic [1:0]              stop_bits,
   input  logic [SAMPLE_WIDTH-1:0] samples_per_bit,
`ifdef UART_TX_BREAK_EN
   input  logic                    send_break,
`endif
   uart_tx_if.slave                tx,
   output logic                    tx_out,
   output logic                    busy,
   output logic [2:0]              state_o
);
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
`ifdef UART_TX_BREAK_EN
      BREAK  = 3'd5,
`endif
      STOP   = 3'd4
   } state_t;
   localparam logic [1:0] ODD_PARITY = 2'd1;
   localparam logic [1:0] EVEN_PARITY = 2'd2;
   localparam logic [SAMPLE_WIDTH-1:0] ONE = 1;

   state_t                  state_q, state_d;
   logic [SAMPLE_WIDTH-1:0] timer_q, timer_d, reload_q, reload_d, spb_m1;
   logic [7:0]              data_q, data_d, data_masked;
   logic [2:0]              cnt_q, cnt_d, last_q, last_d;
   logic [1:0]              stops_q, stops_d;
   logic                    par_en_q, par_en_d, par_bit_q, par_bit_d;
   logic                    tx_out_q, tx_out_d;
   logic                    wide, bit_end, accept, break_req;

`ifdef UART_TX_BREAK_EN
   assign break_req = send_break;
`else
   assign break_req = 1'b0;
`endif
   assign wide        = data_width == 4'd0 || data_width > 4'd8;
   assign data_masked = tx.tx_data & (8'hFF >> (wide ? 4'd0 : 4'd8 - data_width));
   assign spb_m1      = samples_per_bit == '0 ? '0 : samples_per_bit - ONE;
   assign bit_end     = timer_q == '0;
   assign tx.tx_ready = reset && enable && state_q == IDLE && !break_req;
   assign accept      = tx.tx_valid && tx.tx_ready;

   always_comb begin
      state_d   = state_q;
      timer_d   = bit_end ? reload_q : timer_q - ONE;
      reload_d  = reload_q;
      data_d    = data_q;
      cnt_d     = cnt_q;
      last_d    = last_q;
      stops_d   = stops_q;
      par_en_d  = par_en_q;
      par_bit_d = par_bit_q;
      case (state_q)
         IDLE: begin
`ifdef UART_TX_BREAK_EN
            if (send_break) begin
               state_d  = BREAK;
               reload_d = spb_m1;
            end else
`endif
            if (accept) begin
               state_d   = START;
               timer_d   = spb_m1;
               reload_d  = spb_m1;
               data_d    = data_masked;
               last_d    = wide ? 3'd7 : 3'(data_width - 4'd1);
               stops_d   = stop_bits == 2'd0 ? 2'd0 : stop_bits - 2'd1;
               par_en_d  = parity == ODD_PARITY || parity == EVEN_PARITY;
               par_bit_d = ^data_masked ^ (parity == ODD_PARITY);
            end
         end
         START: if (bit_end) begin
            state_d = DATA;
            cnt_d   = '0;
         end
         DATA: if (bit_end) begin
            state_d = cnt_q == last_q ? (par_en_q ? PARITY : STOP) : DATA;
            cnt_d   = cnt_q == last_q ? {1'b0, stops_q} : cnt_q + 3'd1;
         end
         PARITY: if (bit_end) begin
            state_d = STOP;
            cnt_d   = {1'b0, stops_q};
         end
         STOP: if (bit_end) begin
            state_d = cnt_q == '0 ? IDLE : STOP;
            cnt_d   = cnt_q - 3'd1;
         end
`ifdef UART_TX_BREAK_EN
         // Released break is followed by one stop-bit time of idle-high line.
         BREAK: if (!send_break) begin
            state_d = STOP;
            timer_d = reload_q;
            cnt_d   = '0;
         end
`endif
         default: state_d = IDLE;
      endcase
      tx_out_d = state_d == START  ? 1'b0 :
                 state_d == DATA   ? data_d[cnt_d] :
                 state_d == PARITY ? par_bit_d : 1'b1;
`ifdef UART_TX_BREAK_EN
      if (state_d == BREAK) tx_out_d = 1'b0;
`endif
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         timer_q   <= '0;
         reload_q  <= '0;
         data_q    <= '0;
         cnt_q     <= '0;
         last_q    <= '0;
         stops_q   <= '0;
         par_en_q  <= 1'b0;
         par_bit_q <= 1'b0;
         tx_out_q  <= 1'b1;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         reload_q  <= reload_d;
         data_q    <= data_d;
         cnt_q     <= cnt_d;
         last_q    <= last_d;
         stops_q   <= stops_d;
         par_en_q  <= par_en_d;
         par_bit_q <= par_bit_d;
         tx_out_q  <= tx_out_d;
      end
   end

   assign tx_out  = tx_out_q;
   assign busy    = state_q != IDLE;
   assign state_o = state_q;
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: frame-level model of the UART line checked against uart_tx every cycle.
// Break tests run only when UART_TX_BREAK_EN is defined.
module tb_uart_tx;
   typedef struct packed {logic b; logic [2:0] st;} cell_t;

   logic        clk, reset, enable, tx_out, busy, send_break;
   logic [3:0]  data_width;
   logic [1:0]  parity, stop_bits;
   logic [31:0] samples_per_bit;
   logic [2:0]  state_o;
   int          errs = 0, checks = 0;
   cell_t       exp_q[$], frm[$], m_cell;
   logic        cap[$];
   bit          cap_on = 0, brk_m = 0, m_idle;

   uart_tx_if tx();

   uart_tx dut (
      .clk(clk), .reset(reset), .enable(enable), .data_width(data_width),
      .parity(parity), .stop_bits(stop_bits), .samples_per_bit(samples_per_bit),
`ifdef UART_TX_BREAK_EN
      .send_break(send_break),
`endif
      .tx(tx), .tx_out(tx_out), .busy(busy), .state_o(state_o)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", n, act, exp, $time);
      end
   endtask

   function automatic void add(input logic b, input logic [2:0] st, input int sp);
      for (int i = 0; i < sp; i++) frm.push_back(cell_t'({b, st}));
   endfunction

   // Whole frame as a per-cycle list of (line level, state) from the frame rules.
   function automatic void build(input logic [7:0] d, input logic [3:0] dw, input logic [1:0] par,
                                 input logic [1:0] sb, input logic [31:0] spb);
      int n, s, sp;
      logic pb;
      n  = (dw == 0 || dw > 8) ? 8 : int'(dw);
      s  = sb == 0 ? 1 : int'(sb);
      sp = spb == 0 ? 1 : int'(spb);
      pb = 0;
      for (int i = 0; i < n; i++) pb ^= d[i];
      frm.delete();
      add(1'b0, 3'd1, sp);
      for (int i = 0; i < n; i++) add(d[i], 3'd2, sp);
      if (par == 1 || par == 2) add(par == 1 ? ~pb : pb, 3'd3, sp);
      for (int i = 0; i < s; i++) add(1'b1, 3'd4, sp);
   endfunction

   initial forever begin
      @(negedge clk);
      if (cap_on) cap.push_back(tx_out);
      if (!reset) begin
         chk("rst_tx_out", tx_out, 1);
         chk("rst_busy", busy, 0);
         chk("rst_state", state_o, 0);
         chk("rst_ready", tx.tx_ready, 0);
         exp_q.delete();
         brk_m = 0;
      end else begin
         m_idle = exp_q.size() == 0 && !brk_m;
         if (brk_m) m_cell = cell_t'({1'b0, 3'd5});
         else if (m_idle) m_cell = cell_t'({1'b1, 3'd0});
         else m_cell = exp_q[0];
         chk("tx_out", tx_out, m_cell.b);
         chk("busy", busy, !m_idle);
         chk("state", state_o, m_cell.st);
         chk("tx_ready", tx.tx_ready, m_idle && enable && !send_break);
         if (exp_q.size() != 0) void'(exp_q.pop_front());
         if (brk_m && !send_break) begin
            brk_m = 0;
            for (int i = 0; i < (samples_per_bit == 0 ? 1 : int'(samples_per_bit)); i++)
               exp_q.push_back(cell_t'({1'b1, 3'd4}));
         end else if (m_idle && send_break) brk_m = 1;
         else if (m_idle && enable && tx.tx_valid) begin
            build(tx.tx_data, data_width, parity, stop_bits, samples_per_bit);
            foreach (frm[i]) exp_q.push_back(frm[i]);
         end
      end
   end

   task automatic wait_ready(input string n);
      bit ok = 0;
      for (int i = 0; i < 300 && !ok; i++) begin
         @(negedge clk);
         ok = tx.tx_ready;
      end
      chk(n, ok, 1);
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      bit ok = 0;
      for (int i = 0; i < 3000 && !ok; i++) begin
         @(posedge clk);
         ok = exp_q.size() == 0 && !brk_m;
      end
      chk("idle_timeout", ok, 1);
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] d, input logic [3:0] dw, input logic [1:0] par,
                       input logic [1:0] sb, input logic [31:0] spb);
      @(posedge clk);
      #1;
      tx.tx_data = d; data_width = dw; parity = par; stop_bits = sb; samples_per_bit = spb;
      tx.tx_valid = 1;
      wait_ready("accept");
      tx.tx_valid = 0;
   endtask

   function automatic int find_low(input int from);
      for (int i = from; i < cap.size(); i++) if (!cap[i]) return i;
      return -1;
   endfunction

   function automatic logic [7:0] rx_byte(input int s, input int sp);
      logic [7:0] r = '0;
      for (int k = 0; k < 8; k++)
         if (s + sp * (1 + k) + sp / 2 < cap.size()) r[k] = cap[s + sp * (1 + k) + sp / 2];
      return r;
   endfunction

   initial begin
      logic [9:0]  e10;
      logic [10:0] e11;
      int          s, s2, lows;
      reset = 0; enable = 1; send_break = 0;
      tx.tx_valid = 0; tx.tx_data = '0;
      data_width = 4'd8; parity = 2'd0; stop_bits = 2'd1; samples_per_bit = 4;
      e10 = 10'b1101001010;
      build(8'hA5, 4'd8, 2'd0, 2'd1, 4);
      chk("pin_8n1_len", frm.size(), 40);
      for (int k = 0; k < 10; k++) chk("pin_8n1_bit", frm[4 * k].b, e10[k]);
      build(8'hA5, 4'd8, 2'd2, 2'd1, 2);
      chk("pin_8e1_len", frm.size(), 22);
      chk("pin_8e1_par", frm[18].b, 0);
      build(8'hA5, 4'd8, 2'd1, 2'd1, 2);
      chk("pin_8o1_par", frm[18].b, 1);
      e11 = 11'b11010000010;
      build(8'hC1, 4'd7, 2'd2, 2'd2, 1);
      chk("pin_7e2_len", frm.size(), 11);
      for (int k = 0; k < 11; k++) chk("pin_7e2_bit", frm[k].b, e11[k]);
      build(8'h96, 4'd0, 2'd3, 2'd0, 0);
      chk("pin_defaults_len", frm.size(), 10);

      repeat (3) @(posedge clk);
      #1 reset = 1;

      cap.delete(); cap_on = 1;
      send(8'hA5, 4'd8, 2'd0, 2'd1, 4);
      wait_idle();
      cap_on = 0;
      s = find_low(0);
      for (int k = 0; k < 10; k++) chk("dut_8n1_bit", cap[s + 4 * k + 2], e10[k]);

      send(8'hA5, 4'd8, 2'd2, 2'd1, 2);
      wait_idle();
      send(8'hA5, 4'd8, 2'd1, 2'd1, 2);
      wait_idle();
      send(8'hC1, 4'd7, 2'd2, 2'd2, 1);
      wait_idle();
      send(8'h96, 4'd0, 2'd3, 2'd0, 0);
      wait_idle();
      send(8'h01, 4'd9, 2'd1, 2'd3, 3);
      wait_idle();
      send(8'hFF, 4'd1, 2'd2, 2'd1, 2);
      wait_idle();

      cap.delete(); cap_on = 1;
      @(posedge clk);
      #1;
      data_width = 4'd8; parity = 2'd0; stop_bits = 2'd1; samples_per_bit = 2;
      tx.tx_data = 8'h55; tx.tx_valid = 1;
      wait_ready("b2b_first");
      tx.tx_data = 8'h0F;
      wait_ready("b2b_second");
      tx.tx_valid = 0;
      wait_idle();
      cap_on = 0;
      s  = find_low(0);
      s2 = find_low(s + 20);
      chk("b2b_gap", s2 - (s + 20), 1);
      chk("b2b_rx0", rx_byte(s, 2), 8'h55);
      chk("b2b_rx1", rx_byte(s2, 2), 8'h0F);

      send(8'h33, 4'd8, 2'd0, 2'd1, 2);
      enable = 0; tx.tx_data = 8'hAA; tx.tx_valid = 1;
      repeat (30) @(posedge clk);
      #1;
      chk("en_low_idle", busy, 0);
      enable = 1;
      wait_ready("en_resume");
      tx.tx_valid = 0;
      wait_idle();

      send(8'h3C, 4'd8, 2'd0, 2'd1, 4);
      data_width = 4'd5; parity = 2'd2;
      repeat (8) @(posedge clk);
      #1;
      chk("mid_in_data", state_o, 2);
      reset = 0;
      #1;
      chk("mid_rst_tx_out", tx_out, 1);
      chk("mid_rst_busy", busy, 0);
      repeat (2) @(posedge clk);
      #1 reset = 1;
      send(8'h5A, 4'd6, 2'd1, 2'd2, 3);
      wait_idle();

`ifdef UART_TX_BREAK_EN
      cap.delete(); cap_on = 1;
      samples_per_bit = 4;
      @(posedge clk);
      #1 send_break = 1;
      repeat (50) @(posedge clk);
      #1 send_break = 0;
      wait_idle();
      cap_on = 0;
      lows = 0;
      foreach (cap[i]) if (!cap[i]) lows++;
      chk("brk_low_cycles", lows, 50);
      s = find_low(0);
      for (int k = 0; k < 4; k++) chk("brk_stop_high", cap[s + 50 + k], 1);
`endif

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
